// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: WIDTH-bit AND/OR/XOR/NOT logic lane with a 2-stage
// valid/ready pipeline, result flags, chain mode (operand A taken from the
// previous result) and a wrapping completed-operation counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_sel,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_h,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [1:0]       s1_sel_q, s1_sel_d;
    logic             s1_chain_q, s1_chain_d;

    // Stage 2 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_h_q, out_h_d;
    logic             out_zero_q, out_zero_d;
    logic             out_parity_q, out_parity_d;

    logic [WIDTH-1:0] last_result_q, last_result_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // Handshake control and next-state computation for both stages
    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        // rst forces ready high and suppresses any output handshake while it is held
        in_ready = rst || !s1_valid_q || s2_free;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid_q && out_ready && !rst;

        op_a = s1_chain_q ? last_result_q : s1_a_q;
        unique case (s1_sel_q)
            2'b00:   result = op_a & s1_b_q;
            2'b01:   result = op_a | s1_b_q;
            2'b10:   result = op_a ^ s1_b_q;
            default: result = ~op_a;
        endcase

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sel_d   = s1_sel_q;
        s1_chain_d = s1_chain_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_sel_d   = in_sel;
            s1_chain_d = in_chain;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d   = out_valid_q;
        out_h_d       = out_h_q;
        out_zero_d    = out_zero_q;
        out_parity_d  = out_parity_q;
        last_result_d = last_result_q;
        if (s1_adv) begin
            out_valid_d   = 1'b1;
            out_h_d       = result;
            out_zero_d    = (result == '0);
            out_parity_d  = ^result;
            last_result_d = result;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        op_count_d = out_fire ? op_count_q + CNT_W'(1) : op_count_q;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_sel_q      <= '0;
            s1_chain_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_h_q       <= '0;
            out_zero_q    <= 1'b1;
            out_parity_q  <= 1'b0;
            last_result_q <= '0;
            op_count_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_sel_q      <= s1_sel_d;
            s1_chain_q    <= s1_chain_d;
            out_valid_q   <= out_valid_d;
            out_h_q       <= out_h_d;
            out_zero_q    <= out_zero_d;
            out_parity_q  <= out_parity_d;
            last_result_q <= last_result_d;
            op_count_q    <= op_count_d;
        end
    end

    assign out_valid  = out_valid_q && !rst;
    assign out_h      = out_h_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: transaction-level model (queue of accepted
// ops in flight) checked every cycle, plus directed literal expectations.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [1:0] in_sel;
    logic       in_chain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_h;
    logic       out_zero;
    logic       out_parity;
    logic [3:0] op_count;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_h(out_h), .out_zero(out_zero), .out_parity(out_parity),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] h;
        int         cyc;
    } item_t;

    item_t      mq[$];
    logic [9:0] lg[$];       // emitted {parity, zero, h}
    logic [7:0] m_last = '0;
    int         m_cnt  = 0;
    int         cyc    = 0;

    function automatic logic [7:0] lfunc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    always @(negedge clk) begin
        int         n;
        logic       exp_v;
        logic [7:0] r;
        cyc++;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            n = mq.size();
            chk("in_ready", in_ready, (n < 2) || out_ready);
            exp_v = 1'b0;
            if (n > 0) exp_v = (cyc - mq[0].cyc) >= 2;
            chk("out_valid", out_valid, exp_v);
            chk("op_count", op_count, m_cnt);
            if (out_valid && out_ready && n > 0) begin
                chk("out_h", out_h, mq[0].h);
                chk("out_zero", out_zero, mq[0].h == 8'h00);
                chk("out_parity", out_parity, ^mq[0].h);
                lg.push_back({out_parity, out_zero, out_h});
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 16;
            end
            if (in_valid && in_ready) begin
                r = lfunc(in_chain ? m_last : in_a, in_b, in_sel);
                mq.push_back('{h: r, cyc: cyc});
                m_last = r;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s, input logic ch);
        bit ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = s; in_chain = ch;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && mq.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        chk("drain_timeout", mq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; in_chain = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        @(negedge clk);
        chk("rv_out_valid", out_valid, 0);
        chk("rv_out_h", out_h, 8'h00);
        chk("rv_out_zero", out_zero, 1);
        chk("rv_out_parity", out_parity, 0);
        chk("rv_op_count", op_count, 0);
        chk("rv_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // function sweep
        lg.delete();
        issue(8'hF0, 8'hCC, 2'd0, 0);
        issue(8'hF0, 8'hCC, 2'd1, 0);
        issue(8'hF0, 8'hCC, 2'd2, 0);
        issue(8'hF0, 8'hCC, 2'd3, 0);
        drain();
        chk("sweep_and", lg[0], {2'b00, 8'hC0});
        chk("sweep_or",  lg[1], {2'b00, 8'hFC});
        chk("sweep_xor", lg[2], {2'b00, 8'h3C});
        chk("sweep_not", lg[3], {2'b00, 8'h0F});

        // chain, back-to-back
        lg.delete();
        issue(8'hFF, 8'h0F, 2'd0, 0);
        issue(8'h00, 8'hF0, 2'd1, 1);
        issue(8'h00, 8'h00, 2'd3, 1);
        drain();
        chk("chain1", lg[0], {2'b00, 8'h0F});
        chk("chain2", lg[1], {2'b00, 8'hFF});
        chk("chain3", lg[2], {2'b01, 8'h00});

        // flags
        lg.delete();
        issue(8'h01, 8'hFF, 2'd0, 0);
        issue(8'h55, 8'hAA, 2'd0, 0);
        drain();
        chk("flag_par", lg[0], {2'b10, 8'h01});
        chk("flag_zero", lg[1], {2'b01, 8'h00});

        // backpressure, starting from a fresh counter
        do_reset();
        lg.delete();
        out_ready = 1'b0;
        issue(8'h01, 8'h00, 2'd1, 0);
        issue(8'h02, 8'h00, 2'd1, 0);
        fork
            begin
                issue(8'h03, 8'h00, 2'd1, 0);
                issue(8'h04, 8'h00, 2'd1, 0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                #1 chk("bp_in_ready_rise", in_ready, 1);
            end
        join
        drain();
        chk("bp_res0", lg[0], {2'b10, 8'h01});
        chk("bp_res1", lg[1], {2'b10, 8'h02});
        chk("bp_res2", lg[2], {2'b00, 8'h03});
        chk("bp_res3", lg[3], {2'b10, 8'h04});
        chk("bp_count", op_count, 4);

        // reset mid-stream with 2 ops in flight
        out_ready = 1'b0;
        issue(8'hAA, 8'h0F, 2'd0, 0);
        issue(8'h55, 8'h0F, 2'd0, 0);
        do_reset();
        @(negedge clk);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_op_count", op_count, 0);
        chk("mr_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        lg.delete();
        issue(8'hFF, 8'h00, 2'd1, 1);
        drain();
        chk("mr_chain_zero", lg[0], {2'b01, 8'h00});
        chk("mr_count1", op_count, 1);

        // counter wrap at CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) issue(8'(i), 8'hFF, 2'd0, 0);
        drain();
        chk("wrap_count", op_count, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the single-bit combinational logic slice (S1/S0-selected AND/OR/XOR/NOT on Ai, Bi → H). It operates on WIDTH-bit operands, uses a valid/ready handshake on both sides, and registers results through a 2-stage pipeline. It also adds result flags, a chain mode that feeds the previous result back in as operand A, and a completed-operation counter. It sits as the logic-function lane of the ALU datapath, beside the arithmetic lane.

## Interface
- WIDTH, 8, operand/result width (≥1)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A (ignored when in_chain=1)
- in_b  in  WIDTH  operand B
- in_sel  in  2  function select {S1,S0}
- in_chain  in  1  1 = use last computed result as operand A
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_h  out  WIDTH  result
- out_zero  out  1  out_h == 0
- out_parity  out  1  XOR-reduction of out_h
- op_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W

## Operation
- Function per in_sel, bitwise across WIDTH: 00 AND (A&B), 01 OR (A|B), 10 XOR (A^B), 11 NOT (~A, B ignored).
- Stage 1 (S1): on input handshake (in_valid & in_ready), registers in_a, in_b, in_sel, in_chain and sets s1_valid.
- Stage 2 (S2): when S1 advances, computes the function and registers out_h, out_zero, out_parity, and sets out_valid.
  - Operand A is last_result if the registered chain bit is 1; otherwise it is the registered in_a.
- last_result: WIDTH-bit register loaded with the new result each time S2 loads.
  - Chained ops therefore always see the result of the immediately preceding accepted op, with no hazard.
  - last_result is 0 after reset.
- Advance conditions:
  - s2_free = !out_valid | out_ready
  - S1 advances when s1_valid & s2_free
  - in_ready = !s1_valid | s2_free (combinational)
- Output held stable while out_valid & !out_ready; no data dropped or duplicated.
- op_count increments by 1 on each output handshake (out_valid & out_ready) and wraps to 0 after 2^CNT_W−1.
- Reset values: out_valid=0, s1_valid=0, out_h=0, out_zero=1, out_parity=0, last_result=0, op_count=0. in_ready reads 1 during and after reset.

## Timing
- Latency: input handshake in cycle N → out_valid in cycle N+2, provided no backpressure.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure: with out_ready=0, the pipe holds 2 ops, then in_ready drops in the cycle after S1 fills.
  - in_ready rises in the same cycle out_ready rises (combinational path out_ready → in_ready).
- Simultaneous events:
  - Output handshake and S1→S2 transfer in the same cycle: S2 reloads, out_valid stays 1.
  - Input handshake and S1→S2 transfer in the same cycle: S1 reloads, s1_valid stays 1.
- Reset mid-operation: all in-flight ops are discarded, last_result is cleared, and op_count returns to 0. No output handshake occurs in the reset cycle.
- Chain on the first op after reset uses A=0.

## Test plan
- Function sweep, WIDTH=8, out_ready=1: A=0xF0, B=0xCC with sel 00/01/10/11 → out_h 0xC0, 0xFC, 0x3C, 0x0F each 2 cycles after acceptance; parity 0,0,0,0; zero 0.
- Chain: op1 A=0xFF, B=0x0F, sel=00 → 0x0F; op2 chain=1, B=0xF0, sel=01 → 0xFF; op3 chain=1, sel=11 → 0x00 with out_zero=1. All issued back-to-back.
- Backpressure: stream 4 ops with out_ready=0 → in_ready low after 2 accepted. Release out_ready → remaining results emerge in order, none lost, op_count=4.
- Flags: result 0x01 → parity=1, zero=0; result 0x00 → zero=1, parity=0.
- Reset mid-stream: assert rst with 2 ops in flight → next cycle out_valid=0, op_count=0, in_ready=1. A subsequent chain op with sel=01, B=0x00 yields 0x00.
- Counter wrap with CNT_W=4: 17 output handshakes → op_count=1.
